// File: rtl/serializer_pkg.sv
// Shared types and constants for the protobuf serializer host interface.
// Holds the read-slave FSM state encoding, AXI response codes, the register
// map of the read side and fixed bus widths.
package serializer_pkg;

  localparam int ID_W    = 4;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 8;
  localparam int COUNT_W = 10;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    AR_READY = 2'd1,
    R_LOAD   = 2'd2,
    R_VALID  = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [ADDR_W-1:0] ADDR_STATUS = 16'h0000;
  localparam logic [ADDR_W-1:0] ADDR_DATA   = 16'h0001;

  localparam logic [2:0] SIZE_32 = 3'b010;

endpackage

// File: rtl/fsm_1_if.sv
// Read-side bundle of the serializer: AXI4 AR/R channels of slave port s0
// plus the show-ahead serialized-output FIFO read port.
// slave modport = the read FSM; master modport = interconnect + FIFO side.
interface fsm_1_if;
  import serializer_pkg::*;

  // AR channel
  logic [ID_W-1:0]    axs_s0_arid;
  logic [ADDR_W-1:0]  axs_s0_araddr;
  logic [LEN_W-1:0]   axs_s0_arlen;
  logic [2:0]         axs_s0_arsize;
  logic [1:0]         axs_s0_arburst;
  logic               axs_s0_arvalid;
  logic               axs_s0_arready;

  // R channel
  logic [ID_W-1:0]    axs_s0_rid;
  logic [DATA_W-1:0]  axs_s0_rdata;
  logic [1:0]         axs_s0_rresp;
  logic               axs_s0_rlast;
  logic               axs_s0_rvalid;
  logic               axs_s0_rready;

  // Serialized-output FIFO read port
  logic               out_fifo_empty;
  logic [DATA_W-1:0]  out_fifo_rdata;
  logic [COUNT_W-1:0] out_fifo_used;
  logic               out_fifo_pop;

  modport slave (
    input  axs_s0_arid, axs_s0_araddr, axs_s0_arlen, axs_s0_arsize,
    input  axs_s0_arburst, axs_s0_arvalid,
    output axs_s0_arready,
    output axs_s0_rid, axs_s0_rdata, axs_s0_rresp, axs_s0_rlast, axs_s0_rvalid,
    input  axs_s0_rready,
    input  out_fifo_empty, out_fifo_rdata, out_fifo_used,
    output out_fifo_pop
  );

  modport master (
    output axs_s0_arid, axs_s0_araddr, axs_s0_arlen, axs_s0_arsize,
    output axs_s0_arburst, axs_s0_arvalid,
    input  axs_s0_arready,
    input  axs_s0_rid, axs_s0_rdata, axs_s0_rresp, axs_s0_rlast, axs_s0_rvalid,
    output axs_s0_rready,
    output out_fifo_empty, out_fifo_rdata, out_fifo_used,
    input  out_fifo_pop
  );

endinterface

// File: rtl/fsm_1.sv
// AXI4 read-channel slave: serves status (FIFO fill count) and serialized
//   output words from the output FIFO in bursts of arlen+1 beats.
// Latency: AR handshake at edge N -> first rvalid after edge N+1; one beat
//   per 2 cycles. Backpressure: R beat held stable until rready; arready is
//   low for the whole burst; an empty FIFO yields SLVERR beats, never stalls.
// Ports: clk, reset (async active-low), bus (fsm_1_if.slave: AR/R + FIFO).
module fsm_1
  import serializer_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  fsm_1_if.slave bus
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rid_q, rid_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [2:0]         size_q, size_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [1:0]         rresp_q, rresp_d;
  logic               rlast_q, rlast_d;
  logic               rvalid_q, rvalid_d;

  logic               arready;
  logic               fifo_pop;

  // Burst type is accepted but irrelevant: every beat of a data burst reads
  // the FIFO head regardless of INCR/FIXED/WRAP.
  logic               unused_arburst;
  assign unused_arburst = ^bus.axs_s0_arburst;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= INIT;
      rid_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      beat_q   <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rid_q    <= rid_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      beat_q   <= beat_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
      rvalid_q <= rvalid_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next state, beat decode and combinational outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rid_d    = rid_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    beat_d   = beat_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    rvalid_d = rvalid_q;
    arready  = 1'b0;
    fifo_pop = 1'b0;

    unique case (state_q)
      INIT: begin
        state_d = AR_READY;
      end

      AR_READY: begin
        arready = 1'b1;
        if (bus.axs_s0_arvalid) begin
          rid_d   = bus.axs_s0_arid;
          addr_d  = bus.axs_s0_araddr;
          len_d   = bus.axs_s0_arlen;
          size_d  = bus.axs_s0_arsize;
          beat_d  = '0;
          state_d = R_LOAD;
        end
      end

      R_LOAD: begin
        // Each beat is classified on its own, so a data burst that drains
        // the FIFO part-way turns into SLVERR beats instead of stalling.
        if (size_q != SIZE_32) begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end else if (addr_q == ADDR_DATA) begin
          if (!bus.out_fifo_empty) begin
            fifo_pop = 1'b1;
            rdata_d  = bus.out_fifo_rdata;
            rresp_d  = RESP_OKAY;
          end else begin
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
          end
        end else if (addr_q == ADDR_STATUS) begin
          rdata_d = {{(DATA_W-COUNT_W){1'b0}}, bus.out_fifo_used};
          rresp_d = RESP_OKAY;
        end else begin
          rdata_d = '0;
          rresp_d = RESP_DECERR;
        end
        rlast_d  = (beat_q == len_q);
        rvalid_d = 1'b1;
        state_d  = R_VALID;
      end

      R_VALID: begin
        if (bus.axs_s0_rready) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            state_d = AR_READY;
          end else begin
            // rlast flags beat==arlen, so the counter cannot pass 255 here.
            beat_d  = beat_q + 8'd1;
            state_d = R_LOAD;
          end
        end
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

  assign bus.axs_s0_arready = arready;
  assign bus.axs_s0_rid     = rid_q;
  assign bus.axs_s0_rdata   = rdata_q;
  assign bus.axs_s0_rresp   = rresp_q;
  assign bus.axs_s0_rlast   = rlast_q;
  assign bus.axs_s0_rvalid  = rvalid_q;
  assign bus.out_fifo_pop   = fifo_pop;

endmodule

// File: tb/tb_fsm_1.sv
// Bench for fsm_1: table of AR bursts with a queue scoreboard of expected R
// beats, plus hand-written reset, stall and reset-mid-burst sequences.
module tb_fsm_1;

  logic clk = 1'b0;
  logic reset;

  fsm_1_if ifc ();

  fsm_1 dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    int          nwords;
    logic [31:0] w0;
    bit          force_used;
    logic [9:0]  used_val;
    int          exp_pops;
    logic [1:0]  exp_last_resp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  beat_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pop_cnt  = 0;
  int last_hs  = 0;
  int ar_hs    = 0;
  logic [1:0] last_resp = 2'b00;

  // ---------------- output FIFO model (show-ahead) ----------------
  logic [31:0] fifo_mem [0:15];
  int          fifo_rd = 0;
  int          fifo_wr = 0;
  bit          force_used = 1'b0;
  logic [9:0]  used_val = '0;

  assign ifc.out_fifo_empty = (fifo_rd == fifo_wr);
  assign ifc.out_fifo_rdata = (fifo_rd == fifo_wr) ? 32'h0 : fifo_mem[fifo_rd[3:0]];
  assign ifc.out_fifo_used  = force_used ? used_val : 10'(fifo_wr - fifo_rd);

  always @(posedge clk) begin
    if (ifc.out_fifo_pop && (fifo_rd != fifo_wr)) fifo_rd <= fifo_rd + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  beat_t mon_e;
  always @(negedge clk) begin
    if (ifc.out_fifo_pop) pop_cnt++;
    if (reset && ifc.axs_s0_rvalid && ifc.axs_s0_rready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat got rdata=%h resp=%b exp none", ifc.axs_s0_rdata, ifc.axs_s0_rresp);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_rdata", ifc.axs_s0_rdata, mon_e.data);
        chk("beat_rresp", 32'(ifc.axs_s0_rresp), 32'(mon_e.resp));
        chk("beat_rlast", 32'(ifc.axs_s0_rlast), 32'(mon_e.last));
        chk("beat_rid",   32'(ifc.axs_s0_rid),   32'(mon_e.id));
        if (ifc.axs_s0_rlast) begin
          last_hs   = cyc + 1;
          last_resp = ifc.axs_s0_rresp;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic vec_t mk(input logic [3:0] id, input logic [15:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input int nwords, input logic [31:0] w0,
                              input bit fu, input logic [9:0] uv,
                              input int pops, input logic [1:0] lresp);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size;
    v.nwords = nwords; v.w0 = w0; v.force_used = fu; v.used_val = uv;
    v.exp_pops = pops; v.exp_last_resp = lresp;
    return v;
  endfunction

  task automatic load_fifo(input vec_t v);
    fifo_wr = fifo_rd;
    for (int k = 0; k < v.nwords; k++) begin
      fifo_mem[fifo_wr[3:0]] = v.w0 + 32'(k);
      fifo_wr = fifo_wr + 1;
    end
    force_used = v.force_used;
    used_val   = v.used_val;
  endtask

  // Expected beats from the FIFO contents present when the burst starts.
  task automatic push_expected(input vec_t v);
    int avail;
    logic [9:0] used;
    beat_t b;
    avail = fifo_wr - fifo_rd;
    used  = v.force_used ? v.used_val : 10'(avail);
    for (int i = 0; i <= int'(v.len); i++) begin
      b.id   = v.id;
      b.last = (i == int'(v.len));
      if (v.size != 3'b010) begin
        b.data = 32'h0; b.resp = 2'b10;
      end else if (v.addr == 16'h0001) begin
        if (i < avail) begin
          b.data = fifo_mem[4'(fifo_rd + i)]; b.resp = 2'b00;
        end else begin
          b.data = 32'h0; b.resp = 2'b10;
        end
      end else if (v.addr == 16'h0000) begin
        b.data = {22'b0, used}; b.resp = 2'b00;
      end else begin
        b.data = 32'h0; b.resp = 2'b11;
      end
      exp_q.push_back(b);
    end
  endtask

  // Called just after a rising edge; returns just after edge N+1.
  task automatic do_ar(input vec_t v);
    int n;
    bit seen;
    ifc.axs_s0_arid    = v.id;
    ifc.axs_s0_araddr  = v.addr;
    ifc.axs_s0_arlen   = v.len;
    ifc.axs_s0_arsize  = v.size;
    ifc.axs_s0_arburst = 2'b01;
    ifc.axs_s0_arvalid = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      if (ifc.axs_s0_arready) seen = 1'b1;
      else n++;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL ar_timeout got arready=0 exp arready=1 within 50 cycles");
    end
    ar_hs = cyc + 1;
    @(posedge clk);
    #1;
    ifc.axs_s0_arvalid = 1'b0;
    chk("rload_rvalid",  32'(ifc.axs_s0_rvalid),  32'd0);
    chk("rload_arready", 32'(ifc.axs_s0_arready), 32'd0);
    @(posedge clk);
    #1;
    chk("first_rvalid", 32'(ifc.axs_s0_rvalid), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL burst_timeout got %0d beats outstanding exp 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    chk("idle_rvalid", 32'(ifc.axs_s0_rvalid), 32'd0);
  endtask

  task automatic run_entry(input string tag, input vec_t v);
    load_fifo(v);
    ifc.axs_s0_rready = 1'b1;
    pop_cnt = 0;
    push_expected(v);
    do_ar(v);
    wait_idle();
    chk({tag, "_pops"}, 32'(pop_cnt), 32'(v.exp_pops));
    chk({tag, "_last_resp"}, 32'(last_resp), 32'(v.exp_last_resp));
    chk({tag, "_cycles"}, 32'(last_hs - ar_hs), 32'(2 * (int'(v.len) + 1)));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arready"}, 32'(ifc.axs_s0_arready), 32'd0);
    chk({tag, "_rvalid"},  32'(ifc.axs_s0_rvalid),  32'd0);
    chk({tag, "_rlast"},   32'(ifc.axs_s0_rlast),   32'd0);
    chk({tag, "_rid"},     32'(ifc.axs_s0_rid),     32'd0);
    chk({tag, "_rdata"},   ifc.axs_s0_rdata,        32'd0);
    chk({tag, "_rresp"},   32'(ifc.axs_s0_rresp),   32'd0);
    chk({tag, "_pop"},     32'(ifc.out_fifo_pop),   32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  vec_t tbl [8];
  vec_t sv;

  initial begin
    tbl[0] = mk(4'hF, 16'h0001, 8'd0,   3'b010, 1, 32'h1234_5678, 1'b0, 10'd0,  1, 2'b00);
    tbl[1] = mk(4'h3, 16'h0001, 8'd3,   3'b010, 2, 32'hA5A5_0000, 1'b0, 10'd0,  2, 2'b10);
    tbl[2] = mk(4'h5, 16'h0000, 8'd1,   3'b010, 0, 32'h0,         1'b1, 10'd37, 0, 2'b00);
    tbl[3] = mk(4'h6, 16'h0005, 8'd0,   3'b010, 1, 32'hDEAD_0000, 1'b0, 10'd0,  0, 2'b11);
    tbl[4] = mk(4'h7, 16'h0001, 8'd0,   3'b001, 1, 32'hBEEF_0000, 1'b0, 10'd0,  0, 2'b10);
    tbl[5] = mk(4'h9, 16'h0001, 8'd255, 3'b010, 0, 32'h0,         1'b0, 10'd0,  0, 2'b10);
    tbl[6] = mk(4'hA, 16'hFFFF, 8'd2,   3'b010, 0, 32'h0,         1'b0, 10'd0,  0, 2'b11);
    tbl[7] = mk(4'hC, 16'h0001, 8'd1,   3'b010, 3, 32'h0C0C_0100, 1'b0, 10'd0,  2, 2'b00);

    reset = 1'b0;
    ifc.axs_s0_arid    = '0;
    ifc.axs_s0_araddr  = '0;
    ifc.axs_s0_arlen   = '0;
    ifc.axs_s0_arsize  = '0;
    ifc.axs_s0_arburst = '0;
    ifc.axs_s0_arvalid = 1'b0;
    ifc.axs_s0_rready  = 1'b0;

    // Reset held 4 cycles, then released between edges.
    repeat (4) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_release_arready", 32'(ifc.axs_s0_arready), 32'd0);
    @(negedge clk);
    chk("second_edge_arready", 32'(ifc.axs_s0_arready), 32'd1);
    @(posedge clk);
    #1;

    for (int t = 0; t < 8; t++) begin
      run_entry($sformatf("vec%0d", t), tbl[t]);
    end

    // rready held low for 5 cycles with a beat pending.
    sv = mk(4'h2, 16'h0001, 8'd2, 3'b010, 3, 32'h5555_0000, 1'b0, 10'd0, 3, 2'b00);
    load_fifo(sv);
    ifc.axs_s0_rready = 1'b0;
    pop_cnt = 0;
    push_expected(sv);
    do_ar(sv);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_rvalid", 32'(ifc.axs_s0_rvalid), 32'd1);
      chk("stall_rdata",  ifc.axs_s0_rdata,       32'h5555_0000);
      chk("stall_rlast",  32'(ifc.axs_s0_rlast),  32'd0);
    end
    chk("stall_pops", 32'(pop_cnt), 32'd1);
    @(posedge clk);
    #1;
    ifc.axs_s0_rready = 1'b1;
    wait_idle();
    chk("stall_total_pops", 32'(pop_cnt), 32'd3);

    // Reset pulsed in the middle of an 8-beat status burst.
    sv = mk(4'hB, 16'h0000, 8'd7, 3'b010, 0, 32'h0, 1'b1, 10'd99, 0, 2'b00);
    load_fifo(sv);
    ifc.axs_s0_rready = 1'b1;
    push_expected(sv);
    do_ar(sv);
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk_reset_outputs("midburst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midburst_init_arready", 32'(ifc.axs_s0_arready), 32'd0);
    @(negedge clk);
    chk("midburst_recover_arready", 32'(ifc.axs_s0_arready), 32'd1);
    @(posedge clk);
    #1;

    // Normal operation after the abandoned burst.
    run_entry("post_reset", mk(4'hD, 16'h0000, 8'd0, 3'b010, 0, 32'h0, 1'b1, 10'd99, 0, 2'b00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
